// File: rtl/mux_pkg.sv
// Shared definitions for the 2:1 byte-lane recombiner: default widths,
// the idle fill symbol and the arbitration state type.
package mux_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  // K28.5 comma symbol, driven on the stream while idle in fill builds.
  localparam logic [7:0] DEF_IDLE_SYM = 8'hBC;

  // Which lane the recombiner must take the next byte from.
  typedef enum logic {
    EXPECT0 = 1'b0,
    EXPECT1 = 1'b1
  } muxState_e;

  // Lanes strictly alternate, so the next expected lane is always the other one.
  function automatic muxState_e otherLane(input muxState_e s);
    return (s == EXPECT0) ? EXPECT1 : EXPECT0;
  endfunction

endpackage

// File: rtl/lane_fifo.sv
// Per-lane elastic FIFO. Pointers wrap modulo FIFO_DEPTH (a power of two),
// and the count is one bit wider so that full and empty can be told apart.
// Storage is not reset; clearing the pointers and count discards its contents.
module lane_fifo import mux_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                         clk_i,
  input  logic                         resetL_i,
  input  logic                         push_i,
  input  logic [DATA_W-1:0]            pushData_i,
  input  logic                         pop_i,
  output logic [DATA_W-1:0]            headData_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(FIFO_DEPTH):0]  count_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              doPush, doPop;

  // Full and empty depend only on the registered count, so a full FIFO
  // rejects a push even in a cycle where it is also being popped.
  assign full_o     = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign headData_o = mem_q[rdPtr_q];
  assign doPush     = push_i & ~full_o;
  assign doPop      = pop_i & ~empty_o;

  // Next pointer and count values; a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) begin
      wrPtr_d = wrPtr_q + PTR_W'(1);
    end
    if (doPop) begin
      rdPtr_d = rdPtr_q + PTR_W'(1);
    end
    case ({doPush, doPop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count state; reset empties the FIFO immediately.
  always_ff @(posedge clk_i or negedge resetL_i) begin
    if (!resetL_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Data storage, written at the tail on an accepted push.
  always_ff @(posedge clk_i) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= pushData_i;
    end
  end

endmodule

// File: rtl/mux_2x1_8bits.sv
// Recombines the even (lane 0) and odd (lane 1) byte lanes into one stream.
// Each lane has an elastic FIFO; the output takes lane 0, lane 1, lane 0, ...
// and waits on the expected lane rather than skipping it, which keeps the
// original byte order.
// Optional build macro MUX_IDLE_FILL_EN: when defined, data_out carries
// IDLE_SYM in every idle cycle and out of reset; otherwise data_out holds
// its last byte and resets to zero.
module mux_2x1_8bits import mux_pkg::*; #(
  parameter int                DATA_W     = DEF_DATA_W,
  parameter int                FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter logic [DATA_W-1:0] IDLE_SYM   = DATA_W'(DEF_IDLE_SYM)
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [DATA_W-1:0] data_in0,
  input  logic              valid_in0,
  output logic              ready_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic              valid_in1,
  output logic              ready_in1,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              lane_sel
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

`ifdef MUX_IDLE_FILL_EN
  localparam logic [DATA_W-1:0] DATA_RST = IDLE_SYM;
`else
  localparam logic [DATA_W-1:0] DATA_RST = '0;
  logic unusedIdleSym;
  assign unusedIdleSym = ^IDLE_SYM;
`endif

  logic [CNT_W-1:0]  count0, count1;
  logic              full0, full1;
  logic              empty0, empty1;
  logic [DATA_W-1:0] head0, head1;
  logic              push0, push1;
  logic              pop0, pop1;

  muxState_e         sel_q;
  logic [DATA_W-1:0] dataOut_q;
  logic              validOut_q;
  logic              laneSel_q;
  logic              headAvail;
  logic [DATA_W-1:0] headData;

  // Ready comes from the registered count only, never from this cycle's pop.
  // A push needs the same condition, expressed through the FIFO's full flag.
  assign ready_in0 = reset_L & (count0 != CNT_W'(FIFO_DEPTH));
  assign ready_in1 = reset_L & (count1 != CNT_W'(FIFO_DEPTH));
  assign push0     = valid_in0 & reset_L & ~full0;
  assign push1     = valid_in1 & reset_L & ~full1;

  lane_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo0 (
    .clk_i      (clk),
    .resetL_i   (reset_L),
    .push_i     (push0),
    .pushData_i (data_in0),
    .pop_i      (pop0),
    .headData_o (head0),
    .full_o     (full0),
    .empty_o    (empty0),
    .count_o    (count0)
  );

  lane_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo1 (
    .clk_i      (clk),
    .resetL_i   (reset_L),
    .push_i     (push1),
    .pushData_i (data_in1),
    .pop_i      (pop1),
    .headData_o (head1),
    .full_o     (full1),
    .empty_o    (empty1),
    .count_o    (count1)
  );

  // Only the expected lane is examined; the other lane waits even if it has data.
  always_comb begin
    headAvail = 1'b0;
    headData  = head0;
    pop0      = 1'b0;
    pop1      = 1'b0;
    if (sel_q == EXPECT0) begin
      headAvail = ~empty0;
      headData  = head0;
      pop0      = ~empty0;
    end else begin
      headAvail = ~empty1;
      headData  = head1;
      pop1      = ~empty1;
    end
  end

  // Arbitration FSM and output register: emit the expected lane's head and flip lanes, else go idle.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      sel_q      <= EXPECT0;
      validOut_q <= 1'b0;
      dataOut_q  <= DATA_RST;
      laneSel_q  <= 1'b1;
    end else if (headAvail) begin
      dataOut_q  <= headData;
      validOut_q <= 1'b1;
      laneSel_q  <= (sel_q == EXPECT1);
      sel_q      <= otherLane(sel_q);
    end else begin
      validOut_q <= 1'b0;
`ifdef MUX_IDLE_FILL_EN
      dataOut_q  <= IDLE_SYM;
`endif
    end
  end

  assign data_out  = dataOut_q;
  assign valid_out = validOut_q;
  assign lane_sel  = laneSel_q;

endmodule

// File: tb/tb_mux_2x1_8bits.sv
// Directed testbench for the 2:1 byte-lane recombiner. Inputs are driven
// 1 ns after each rising edge; outputs are sampled at the same point.
module tb_mux_2x1_8bits;

`ifdef MUX_IDLE_FILL_EN
  localparam logic [7:0] IDLE_EXP = 8'hBC;
  localparam bit         FILL     = 1'b1;
`else
  localparam logic [7:0] IDLE_EXP = 8'h00;
  localparam bit         FILL     = 1'b0;
`endif

  logic       clk;
  logic       reset_L;
  logic [7:0] data_in0, data_in1;
  logic       valid_in0, valid_in1;
  logic       ready_in0, ready_in1;
  logic [7:0] data_out;
  logic       valid_out;
  logic       lane_sel;

  int checks = 0;
  int failures = 0;

  mux_2x1_8bits dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .data_in0  (data_in0),
    .valid_in0 (valid_in0),
    .ready_in0 (ready_in0),
    .data_in1  (data_in1),
    .valid_in1 (valid_in1),
    .ready_in1 (ready_in1),
    .data_out  (data_out),
    .valid_out (valid_out),
    .lane_sel  (lane_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor: records every emitted byte with its lane and cycle stamp.
  int         cyc = 0;
  logic [7:0] outQ[$];
  bit         laneQ[$];
  int         stampQ[$];

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (valid_out === 1'b1) begin
      outQ.push_back(data_out);
      laneQ.push_back(lane_sel);
      stampQ.push_back(cyc);
    end
  end

  // Per-lane source queues with hold-until-accepted handshake.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit         offer0 = 1'b0;
  bit         offer1 = 1'b0;

  task automatic clearOut();
    outQ.delete();
    laneQ.delete();
    stampQ.delete();
  endtask

  task automatic applyStimulus(input int cycles, input int gapPct);
    bit acc0, acc1;
    for (int i = 0; i < cycles; i++) begin
      if (!offer0 && q0.size() > 0) offer0 = (int'($urandom_range(99)) >= gapPct);
      if (!offer1 && q1.size() > 0) offer1 = (int'($urandom_range(99)) >= gapPct);
      valid_in0 = offer0;
      valid_in1 = offer1;
      if (offer0) data_in0 = q0[0];
      if (offer1) data_in1 = q1[0];
      acc0 = offer0 && (ready_in0 === 1'b1);
      acc1 = offer1 && (ready_in1 === 1'b1);
      @(posedge clk);
      #1;
      if (acc0) begin
        void'(q0.pop_front());
        offer0 = 1'b0;
      end
      if (acc1) begin
        void'(q1.pop_front());
        offer1 = 1'b0;
      end
    end
    valid_in0 = offer0;
    valid_in1 = offer1;
  endtask

  task automatic test_reset();
    reset_L   = 1'b0;
    valid_in0 = 1'b1;
    valid_in1 = 1'b1;
    data_in0  = 8'hAA;
    data_in1  = 8'h55;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ready_in0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready0: got %b expected 0", ready_in0); end
    checks++;
    if (ready_in1 !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready1: got %b expected 0", ready_in1); end
    checks++;
    if (valid_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", valid_out); end
    checks++;
    if (data_out !== IDLE_EXP) begin failures++; $display("[TB] FAIL reset_data: got %h expected %h", data_out, IDLE_EXP); end
    checks++;
    if (lane_sel !== 1'b1) begin failures++; $display("[TB] FAIL reset_lane_sel: got %b expected 1", lane_sel); end
    valid_in0 = 1'b0;
    valid_in1 = 1'b0;
    reset_L   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ready_in0, ready_in1} !== 2'b11) begin failures++; $display("[TB] FAIL release_ready: got %b expected 11", {ready_in0, ready_in1}); end
    checks++;
    if (outQ.size() != 0) begin failures++; $display("[TB] FAIL reset_no_push: got %0d bytes expected 0", outQ.size()); end
  endtask

  task automatic test_ordered_merge();
    int startCyc;
    clearOut();
    startCyc = cyc;
    q0 = '{8'h00, 8'h02, 8'h04, 8'h06};
    q1 = '{8'h01, 8'h03, 8'h05, 8'h07};
    applyStimulus(12, 0);
    checks++;
    if (outQ.size() != 8) begin failures++; $display("[TB] FAIL merge_count: got %0d expected 8", outQ.size()); end
    for (int i = 0; i < 8 && i < outQ.size(); i++) begin
      checks++;
      if (outQ[i] !== 8'(i) || laneQ[i] !== bit'(i % 2) || stampQ[i] != startCyc + 2 + i) begin
        failures++;
        $display("[TB] FAIL merge_byte%0d: got data=%h lane=%b cyc=%0d expected data=%h lane=%0d cyc=%0d",
                 i, outQ[i], laneQ[i], stampQ[i], 8'(i), i % 2, startCyc + 2 + i);
      end
    end
  endtask

  task automatic test_starvation();
    int startCyc;
    logic [7:0] expData[4];
    bit         expLane[4];
    int         expStamp[4];
    logic [7:0] holdExp;
    expData  = '{8'h10, 8'h11, 8'h12, 8'h13};
    expLane  = '{1'b0, 1'b1, 1'b0, 1'b1};
    expStamp = '{2, 7, 8, 9};
    holdExp  = FILL ? IDLE_EXP : 8'h10;
    clearOut();
    startCyc = cyc;
    for (int c = 0; c < 12; c++) begin
      valid_in0 = (c < 2);
      data_in0  = (c == 0) ? 8'h10 : 8'h12;
      valid_in1 = (c == 5) || (c == 6);
      data_in1  = (c == 5) ? 8'h11 : 8'h13;
      @(posedge clk);
      #1;
      if (c == 3) begin
        checks++;
        if (valid_out !== 1'b0 || data_out !== holdExp || lane_sel !== 1'b0) begin
          failures++;
          $display("[TB] FAIL starve_idle: got valid=%b data=%h lane=%b expected valid=0 data=%h lane=0",
                   valid_out, data_out, lane_sel, holdExp);
        end
      end
    end
    valid_in0 = 1'b0;
    valid_in1 = 1'b0;
    checks++;
    if (outQ.size() != 4) begin failures++; $display("[TB] FAIL starve_count: got %0d expected 4", outQ.size()); end
    for (int i = 0; i < 4 && i < outQ.size(); i++) begin
      checks++;
      if (outQ[i] !== expData[i] || laneQ[i] !== expLane[i] || stampQ[i] != startCyc + expStamp[i]) begin
        failures++;
        $display("[TB] FAIL starve_byte%0d: got data=%h lane=%b cyc=%0d expected data=%h lane=%b cyc=%0d",
                 i, outQ[i], laneQ[i], stampQ[i], expData[i], expLane[i], startCyc + expStamp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] holdExp;
    holdExp = FILL ? IDLE_EXP : 8'h20;
    clearOut();
    q0 = '{8'h20, 8'h22, 8'h24, 8'h26, 8'h28, 8'h2A, 8'h2C};
    applyStimulus(4, 0);
    checks++;
    if (ready_in0 !== 1'b1) begin failures++; $display("[TB] FAIL bp_ready_at3: got %b expected 1", ready_in0); end
    applyStimulus(1, 0);
    checks++;
    if (ready_in0 !== 1'b0) begin failures++; $display("[TB] FAIL bp_ready_full: got %b expected 0", ready_in0); end
    checks++;
    if (valid_out !== 1'b0 || data_out !== holdExp) begin
      failures++;
      $display("[TB] FAIL bp_idle: got valid=%b data=%h expected valid=0 data=%h", valid_out, data_out, holdExp);
    end
    applyStimulus(3, 0);
    checks++;
    if (ready_in0 !== 1'b0 || q0.size() != 2) begin
      failures++;
      $display("[TB] FAIL bp_hold: got ready=%b pending=%0d expected ready=0 pending=2", ready_in0, q0.size());
    end
    q1 = '{8'h21, 8'h23, 8'h25, 8'h27, 8'h29, 8'h2B, 8'h2D};
    applyStimulus(25, 0);
    checks++;
    if (outQ.size() != 14) begin failures++; $display("[TB] FAIL bp_count: got %0d expected 14", outQ.size()); end
    for (int i = 0; i < 14 && i < outQ.size(); i++) begin
      checks++;
      if (outQ[i] !== 8'(8'h20 + i) || laneQ[i] !== bit'(i % 2)) begin
        failures++;
        $display("[TB] FAIL bp_byte%0d: got data=%h lane=%b expected data=%h lane=%0d",
                 i, outQ[i], laneQ[i], 8'(8'h20 + i), i % 2);
      end
    end
  endtask

  task automatic test_wraparound();
    clearOut();
    for (int i = 0; i < 64; i += 2) begin
      q0.push_back(8'(i));
      q1.push_back(8'(i + 1));
    end
    applyStimulus(250, 30);
    checks++;
    if (q0.size() != 0 || q1.size() != 0 || outQ.size() != 64) begin
      failures++;
      $display("[TB] FAIL wrap_count: got out=%0d left0=%0d left1=%0d expected out=64 left0=0 left1=0",
               outQ.size(), q0.size(), q1.size());
    end
    for (int i = 0; i < 64 && i < outQ.size(); i++) begin
      checks++;
      if (outQ[i] !== 8'(i) || laneQ[i] !== bit'(i % 2)) begin
        failures++;
        $display("[TB] FAIL wrap_byte%0d: got data=%h lane=%b expected data=%h lane=%0d",
                 i, outQ[i], laneQ[i], 8'(i), i % 2);
      end
    end
  endtask

  task automatic test_mid_reset();
    clearOut();
    q0 = '{8'hB0, 8'hB2, 8'hB4};
    q1 = '{8'hB1, 8'hB3};
    applyStimulus(3, 0);
    checks++;
    if (valid_out !== 1'b1 || data_out !== 8'hB1) begin
      failures++;
      $display("[TB] FAIL mrst_pre: got valid=%b data=%h expected valid=1 data=b1", valid_out, data_out);
    end
    #2;
    reset_L = 1'b0;
    #1;
    checks++;
    if (valid_out !== 1'b0 || data_out !== IDLE_EXP || lane_sel !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mrst_async: got valid=%b data=%h lane=%b expected valid=0 data=%h lane=1",
               valid_out, data_out, lane_sel, IDLE_EXP);
    end
    checks++;
    if ({ready_in0, ready_in1} !== 2'b00) begin failures++; $display("[TB] FAIL mrst_ready: got %b expected 00", {ready_in0, ready_in1}); end
    #2;
    reset_L = 1'b1;
    clearOut();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (outQ.size() != 0 || {ready_in0, ready_in1} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL mrst_flushed: got out=%0d ready=%b expected out=0 ready=11", outQ.size(), {ready_in0, ready_in1});
    end
    q0 = '{8'hA0};
    q1 = '{8'hA1};
    applyStimulus(5, 0);
    checks++;
    if (outQ.size() != 2) begin
      failures++;
      $display("[TB] FAIL mrst_restart_count: got %0d expected 2", outQ.size());
    end else if (outQ[0] !== 8'hA0 || laneQ[0] !== 1'b0 || outQ[1] !== 8'hA1 || laneQ[1] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mrst_restart: got %h/%b %h/%b expected a0/0 a1/1", outQ[0], laneQ[0], outQ[1], laneQ[1]);
    end
  endtask

  initial begin
    data_in0  = 8'h00;
    data_in1  = 8'h00;
    valid_in0 = 1'b0;
    valid_in1 = 1'b0;
    reset_L   = 1'b0;
    test_reset();
    test_ordered_merge();
    test_starvation();
    test_backpressure();
    test_wraparound();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guards against a hang; every test above runs for a fixed number of cycles.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
